// File: rtl/mips_loader_pkg.sv
// Shared types and defaults for the MIPS program loader.
// State encodings, default end marker and byte-counter width.
package mips_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loaderState_t;

    localparam logic [31:0] DEFAULT_END_MARKER = 32'hFFFF_FFFF;
    localparam int          BYTE_CNT_W         = 2;

endpackage

// File: rtl/loader_word_assembler.sv
// Big-endian byte-to-word packer for the program loader.
// The 4th byte goes straight onto the word output, so wordReady and the full word are valid in the same cycle.
module loader_word_assembler
    import mips_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byteValid,
    input  logic [7:0]  byteIn,
    output logic [31:0] word,
    output logic        wordReady
);

    // Only the three oldest bytes need storage; the newest byte arrives on byteIn.
    logic [23:0]           shiftReg;
    logic [BYTE_CNT_W-1:0] byteCnt;

    assign word      = {shiftReg, byteIn};
    assign wordReady = byteValid && (byteCnt == '1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shiftReg <= '0;
            byteCnt  <= '0;
        end else if (byteValid) begin
            shiftReg <= word[23:0];
            byteCnt  <= byteCnt + 1'b1;
        end
    end

endmodule

// File: rtl/mips_program_loader.sv
// Streams bytes into instruction memory as big-endian words and holds the CPU until the end marker lands.
// Optional trailing XOR checksum byte is enabled with LOADER_CHECKSUM_EN.
module mips_program_loader
    import mips_loader_pkg::*;
#(
    parameter int          ADDR_W     = 5,
    parameter int          DEPTH      = 32,
    parameter logic [31:0] END_MARKER = DEFAULT_END_MARKER
)(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [7:0]        RxData,
    input  logic              RxValid,
    output logic              RxReady,
    output logic              IMemWrEn,
    output logic [ADDR_W-1:0] IMemWrAddr,
    output logic [31:0]       IMemWrData,
    output logic [ADDR_W:0]   WordCount,
    output logic              CpuHold,
    output logic              Done,
    output logic              Error
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    loaderState_t      state;
    logic [ADDR_W-1:0] wordIdx;
    logic [31:0]       asmWord;
    logic              wordReady;
    logic              byteAccept;
    logic              startLoad;

    // Start is honoured only where no load is in progress.
    assign startLoad  = Start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
    assign byteAccept = RxValid && RxReady && (state == ST_LOAD);

    loader_word_assembler uAsm (
        .clk       (Clock),
        .reset     (Reset),
        .clear     (startLoad),
        .byteValid (byteAccept),
        .byteIn    (RxData),
        .word      (asmWord),
        .wordReady (wordReady)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] xorSum;

    always_ff @(posedge Clock) begin
        if (Reset || startLoad)
            xorSum <= '0;
        else if (byteAccept)
            xorSum <= xorSum ^ RxData;
    end
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= ST_IDLE;
            wordIdx    <= '0;
            RxReady    <= 1'b0;
            IMemWrEn   <= 1'b0;
            IMemWrAddr <= '0;
            IMemWrData <= '0;
            WordCount  <= '0;
            CpuHold    <= 1'b1;
            Done       <= 1'b0;
            Error      <= 1'b0;
        end else begin
            IMemWrEn <= 1'b0;
            if (startLoad) begin
                state     <= ST_LOAD;
                wordIdx   <= '0;
                WordCount <= '0;
                RxReady   <= 1'b1;
                CpuHold   <= 1'b1;
                Done      <= 1'b0;
                Error     <= 1'b0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (wordReady) begin
                            state      <= ST_WRITE;
                            RxReady    <= 1'b0;
                            IMemWrEn   <= 1'b1;
                            IMemWrAddr <= wordIdx;
                            IMemWrData <= asmWord;
                        end
                    end
                    ST_WRITE: begin
                        WordCount <= WordCount + 1'b1;
                        if (IMemWrData == END_MARKER) begin
`ifdef LOADER_CHECKSUM_EN
                            state   <= ST_CHECK;
                            RxReady <= 1'b1;
`else
                            state   <= ST_DONE;
                            CpuHold <= 1'b0;
                            Done    <= 1'b1;
`endif
                        end else if (wordIdx == LAST_IDX) begin
                            // Memory full and still no marker: the image is unusable.
                            state <= ST_ERROR;
                            Error <= 1'b1;
                        end else begin
                            state   <= ST_LOAD;
                            wordIdx <= wordIdx + 1'b1;
                            RxReady <= 1'b1;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    ST_CHECK: begin
                        if (RxValid && RxReady) begin
                            RxReady <= 1'b0;
                            if (RxData == xorSum) begin
                                state   <= ST_DONE;
                                CpuHold <= 1'b0;
                                Done    <= 1'b1;
                            end else begin
                                state <= ST_ERROR;
                                Error <= 1'b1;
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_program_loader.sv
// Randomized self-checking bench for mips_program_loader against a stream-level reference model.
// Checksum scenarios follow LOADER_CHECKSUM_EN when it is defined for the build.
module tb_mips_program_loader;

    localparam int          ADDR_W = 5;
    localparam int          DEPTH  = 32;
    localparam logic [31:0] MARKER = 32'hFFFF_FFFF;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              Clock = 1'b0;
    logic              Reset, Start, RxValid;
    logic [7:0]        RxData;
    logic              RxReady, IMemWrEn, CpuHold, Done, Error;
    logic [ADDR_W-1:0] IMemWrAddr;
    logic [31:0]       IMemWrData;
    logic [ADDR_W:0]   WordCount;

    mips_program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .END_MARKER(MARKER)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .RxData(RxData), .RxValid(RxValid),
        .RxReady(RxReady), .IMemWrEn(IMemWrEn), .IMemWrAddr(IMemWrAddr), .IMemWrData(IMemWrData),
        .WordCount(WordCount), .CpuHold(CpuHold), .Done(Done), .Error(Error)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe observed mid-cycle is logged.
    logic [ADDR_W-1:0] gotA[$];
    logic [31:0]       gotD[$];
    always @(negedge Clock) begin
        if (IMemWrEn === 1'b1) begin
            gotA.push_back(IMemWrAddr);
            gotD.push_back(IMemWrData);
        end
    end

    // Reference model: walk the byte stream, group into words, apply the termination rules.
    logic [7:0]  stim[$];
    logic [31:0] expD[$];
    int          expOutcome;   // 0 = still loading, 1 = done, 2 = error

    task automatic modelRun();
        logic [31:0] w = '0;
        logic [7:0]  x = '0;
        int          nb = 0;
        bit          awaitChk = 1'b0;
        expD.delete();
        expOutcome = 0;
        foreach (stim[i]) begin
            if (expOutcome != 0) break;
            if (awaitChk) begin
                expOutcome = (stim[i] == x) ? 1 : 2;
                break;
            end
            w = {w[23:0], stim[i]};
            x ^= stim[i];
            nb++;
            if (nb == 4) begin
                nb = 0;
                expD.push_back(w);
                if (w == MARKER) begin
                    if (CHK) awaitChk = 1'b1;
                    else     expOutcome = 1;
                end else if (expD.size() == DEPTH) begin
                    expOutcome = 2;
                end
            end
        end
    endtask

    task automatic buildRandom(input int nWords, input bit withMarker, input int extra, input bit goodSum);
        logic [7:0] x = '0;
        stim.delete();
        repeat (nWords) begin
            logic [31:0] w = $urandom();
            if (w == MARKER) w = 32'h0;
            for (int b = 3; b >= 0; b--) stim.push_back(w[8*b +: 8]);
        end
        if (withMarker) begin
            repeat (4) stim.push_back(8'hFF);
            foreach (stim[i]) x ^= stim[i];
            if (CHK) stim.push_back(goodSum ? x : (x ^ 8'h5A));
        end else begin
            repeat (extra) stim.push_back(8'($urandom()));
        end
    endtask

    task automatic pulseStart();
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic doReset(input int n);
        Reset = 1'b1;
        repeat (n) @(negedge Clock);
        Reset = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge just after the byte is taken.
    task automatic sendByte(input logic [7:0] b);
        int t = 0;
        RxData  = b;
        RxValid = 1'b1;
        while (RxReady !== 1'b1 && t < 40) begin
            @(negedge Clock);
            t++;
        end
        if (RxReady !== 1'b1) begin
            chk("rdyTimeout", 64'(RxReady), 64'd1);
            return;
        end
        @(negedge Clock);
    endtask

    task automatic sendStream(input int maxGap);
        for (int k = 0; k < stim.size(); k++) begin
            int g = (maxGap > 0) ? $urandom_range(maxGap, 0) : 0;
            if (g > 0) begin
                RxValid = 1'b0;
                repeat (g) @(negedge Clock);
            end
            sendByte(stim[k]);
            if (k % 4 == 3) begin
                chk("wrStrobe", 64'(IMemWrEn), 64'd1);
                chk("wrRdyLow", 64'(RxReady), 64'd0);
                chk("wrAddr", 64'(IMemWrAddr), 64'(k / 4));
            end else begin
                chk("noStrobe", 64'(IMemWrEn), 64'd0);
            end
        end
        RxValid = 1'b0;
    endtask

    task automatic compareResults();
        chk("nWrites", 64'(gotD.size()), 64'(expD.size()));
        for (int i = 0; i < expD.size() && i < gotD.size(); i++) begin
            chk("wAddr", 64'(gotA[i]), 64'(i));
            chk("wData", 64'(gotD[i]), 64'(expD[i]));
        end
        chk("wordCount", 64'(WordCount), 64'(expD.size()));
        chk("done", 64'(Done), 64'(expOutcome == 1));
        chk("error", 64'(Error), 64'(expOutcome == 2));
        chk("cpuHold", 64'(CpuHold), 64'(expOutcome != 1));
        chk("rxReady", 64'(RxReady), 64'(expOutcome == 0));
    endtask

    task automatic runScenario(input int maxGap);
        modelRun();
        gotA.delete();
        gotD.delete();
        pulseStart();
        chk("startHold", 64'(CpuHold), 64'd1);
        chk("startDone", 64'(Done), 64'd0);
        chk("startWc", 64'(WordCount), 64'd0);
        sendStream(maxGap);
        repeat (3) @(negedge Clock);
        compareResults();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Start   = 1'b0;
        RxValid = 1'b1;
        RxData  = 8'hAB;
        Reset   = 1'b1;

        // Reset held with a valid byte on the bus.
        repeat (10) begin
            @(negedge Clock);
            chk("rstHold", 64'(CpuHold), 64'd1);
            chk("rstRdy", 64'(RxReady), 64'd0);
            chk("rstDone", 64'(Done), 64'd0);
            chk("rstWr", 64'(IMemWrEn), 64'd0);
        end
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        chk("idleRdy", 64'(RxReady), 64'd0);
        chk("idleWc", 64'(WordCount), 64'd0);
        chk("idleAddr", 64'(IMemWrAddr), 64'd0);
        chk("idleData", 64'(IMemWrData), 64'd0);
        chk("idleErr", 64'(Error), 64'd0);
        chk("idleNoWr", 64'(gotD.size()), 64'd0);
        RxValid = 1'b0;

        // Directed program: one instruction plus marker, bytes back-to-back.
        stim = '{8'h20, 8'h11, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        if (CHK) stim.push_back(8'h34);
        runScenario(0);
        if (gotD.size() >= 2) begin
            chk("t2w0", 64'(gotD[0]), 64'h20110005);
            chk("t2w1", 64'(gotD[1]), 64'hFFFFFFFF);
        end

        // Fill the whole memory without a marker, then reload from address 0.
        buildRandom(DEPTH, 1'b0, 0, 1'b1);
        runScenario(1);
        buildRandom(2, 1'b1, 0, 1'b1);
        runScenario(2);

        // Reset mid-word: partial bytes are dropped, next load starts clean.
        stim = '{8'hDE, 8'hAD};
        gotD.delete();
        pulseStart();
        sendStream(0);
        doReset(2);
        repeat (2) @(negedge Clock);
        chk("partNoWr", 64'(gotD.size()), 64'd0);
        chk("partWc", 64'(WordCount), 64'd0);
        buildRandom(1, 1'b1, 0, 1'b1);
        runScenario(0);

        // Checksum sample stream: correct byte, then a wrong one.
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        if (CHK) stim.push_back(8'h04);
        runScenario(0);
        if (CHK) begin
            stim[8] = 8'h05;
            runScenario(0);
        end

        // Randomized loads: mix of finished, bad-checksum and stalled partial streams.
        for (int r = 0; r < 12; r++) begin
            int mode = $urandom_range(3, 0);
            int nW   = $urandom_range(5, 1);
            int gap  = (r % 3 == 0) ? 0 : 3;
            if (mode == 0) begin
                buildRandom(nW, 1'b0, $urandom_range(3, 1), 1'b1);
                runScenario(gap);
                pulseStart();
                @(negedge Clock);
                chk("startIgnored", 64'(WordCount), 64'(expD.size()));
                doReset(1);
            end else begin
                buildRandom(nW, 1'b1, 0, mode != 1);
                runScenario(gap);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
